// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch unit: state encoding and
// fetch constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/state control plus the IF/ID output register
// feeding decode through a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic         valid_nx;
    logic [31:0]  opc_nx, oinstr_nx;
    logic         handshake;
    logic         redir_mis;
    logic [31:0]  redir_tgt;

    assign imem_addr = pc;
    assign fault     = (state == ST_FAULT);
    assign handshake = out_valid & id_ready;
    assign redir_mis = (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // Redirect outranks everything; a misaligned target is word-aligned and faults.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        valid_nx  = out_valid;
        opc_nx    = out_pc;
        oinstr_nx = out_instr;
        case (state)
            ST_BOOT: begin
                state_nx = ST_RUN;
                if (redirect_valid) begin
                    pc_nx    = redir_tgt;
                    state_nx = redir_mis ? ST_FAULT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_nx    = redir_tgt;
                    valid_nx = 1'b0;
                    state_nx = redir_mis ? ST_FAULT : ST_RUN;
                end else if (!out_valid || id_ready) begin
                    if (imem_instr == 32'h0000_0000) begin
                        state_nx = ST_FAULT;
                        valid_nx = 1'b0;
                    end else begin
                        opc_nx    = pc;
                        oinstr_nx = imem_instr;
                        valid_nx  = 1'b1;
                        pc_nx     = pc + PC_INC;
                    end
                end
            end
            ST_FAULT: begin
                valid_nx = 1'b0;
                if (redirect_valid) begin
                    pc_nx    = redir_tgt;
                    state_nx = redir_mis ? ST_FAULT : ST_RUN;
                end
            end
            default: begin
                state_nx = ST_BOOT;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= NOP_INSTR;
            fetch_count <= '0;
        end else begin
            pc        <= pc_nx;
            out_valid <= valid_nx;
            out_pc    <= opc_nx;
            out_instr <= oinstr_nx;
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check32({tag, "_pc"},    out_pc,             32'd0);
        check32({tag, "_instr"}, out_instr,          32'h0000_0013);
        check32({tag, "_fault"}, {31'd0, fault},     32'd0);
        check32({tag, "_cnt"},   fetch_count,        32'd0);
        check32({tag, "_addr"},  imem_addr,          32'd0);
    endtask

    // Reset is asserted between edges, held over one edge, released 1 after it.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0010_0093 + (i << 7);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0030_0113;
        mem[2] = 32'h0062_b3b3;
        mem[3] = 32'h0020_a023;
        mem[4] = 32'h0000_0013;
        mem[5] = 32'h0000_0000;

        #2;
        // Sequential run into the zero word at 0x14.
        do_reset("rst0");
        id_ready = 1'b1;
        tick();
        check32("boot_valid", {31'd0, out_valid}, 32'd0);
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            check32($sformatf("seq_pc%0d", k),    out_pc,             k * 4);
            check32($sformatf("seq_v%0d", k),     {31'd0, out_valid}, 32'd1);
            check32($sformatf("seq_cnt%0d", k),   fetch_count,        k);
        end
        check32("seq_instr2_chk", mem[2], 32'h0062_b3b3);
        tick();
        check32("ill_fault", {31'd0, fault},     32'd1);
        check32("ill_valid", {31'd0, out_valid}, 32'd0);
        check32("ill_addr",  imem_addr,          32'h14);
        check32("seq_cnt5",  fetch_count,        32'd5);
        for (int unsigned k = 0; k < 4; k++) begin
            id_ready = k[0];
            tick();
            check32($sformatf("ill_hold_f%0d", k), {31'd0, fault},     32'd1);
            check32($sformatf("ill_hold_a%0d", k), imem_addr,          32'h14);
            check32($sformatf("ill_hold_v%0d", k), {31'd0, out_valid}, 32'd0);
        end
        check32("ill_cnt", fetch_count, 32'd5);

        // Stall at out_pc=8, then redirect under stall.
        id_ready = 1'b1;
        do_reset("rst1");
        tick();
        tick();
        tick();
        tick();
        check32("pre_stall_pc", out_pc, 32'd8);
        id_ready = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            check32($sformatf("stall_pc%0d", k),  out_pc,      32'd8);
            check32($sformatf("stall_in%0d", k),  out_instr,   32'h0062_b3b3);
            check32($sformatf("stall_ad%0d", k),  imem_addr,   32'd12);
            check32($sformatf("stall_cnt%0d", k), fetch_count, 32'd2);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check32("redir_valid", {31'd0, out_valid}, 32'd0);
        check32("redir_addr",  imem_addr,          32'h40);
        check32("redir_cnt",   fetch_count,        32'd2);
        tick();
        check32("redir_pc",  out_pc,             32'h40);
        check32("redir_v1",  {31'd0, out_valid}, 32'd1);
        check32("redir_in",  out_instr,          mem[16]);

        // Misaligned redirect, then recovery.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check32("mis_fault", {31'd0, fault},     32'd1);
        check32("mis_addr",  imem_addr,          32'h40);
        check32("mis_valid", {31'd0, out_valid}, 32'd0);
        redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check32("rec_fault", {31'd0, fault},     32'd0);
        check32("rec_addr",  imem_addr,          32'h10);
        tick();
        check32("rec_pc",    out_pc,             32'h10);
        check32("rec_valid", {31'd0, out_valid}, 32'd1);
        check32("rec_instr", out_instr,          32'h0000_0013);

        // Reset mid-operation.
        id_ready = 1'b1;
        do_reset("rst2");
        tick();
        check32("mid_boot_v", {31'd0, out_valid}, 32'd0);
        tick();
        check32("mid_first_v",  {31'd0, out_valid}, 32'd1);
        check32("mid_first_pc", out_pc,             32'd0);

        // Redirect during BOOT.
        do_reset("rst3");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check32("boot_redir_addr",  imem_addr,          32'h40);
        check32("boot_redir_fault", {31'd0, fault},     32'd0);
        check32("boot_redir_v",     {31'd0, out_valid}, 32'd0);
        tick();
        check32("boot_redir_pc", out_pc, 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
